servo_sweep_pwm: RTL and testbench
==================================

Name: servo_sweep_pwm

Overview:
- Parametrised servo PWM generator with position sequencing for the radar scan head.
- Produces a fixed-period PWM frame whose high time is the current position, in clock cycles.
- Modes: hold, continuous triangular sweep between limits, or handshake-commanded move to a target.
- Exports position, direction and frame-start so the ranging logic can tag each echo with a bearing.

Parameters:
- W, 20, width of counters, positions and pulse widths; requires PERIOD_CYC < 2^W.
- PERIOD_CYC, 540000, PWM frame length in clk cycles (20 ms at 27 MHz).
- MIN_PULSE, 16000, lower position limit in cycles.
- MAX_PULSE, 66000, upper position limit in cycles; must satisfy MIN_PULSE < MAX_PULSE < PERIOD_CYC.
- RESET_POS, 41000, position after reset; must lie within [MIN_PULSE, MAX_PULSE].
- STEP, 1, position increment per step tick.
- STEP_INTERVAL, 2500, clk cycles between step ticks.
- DWELL_FRAMES, 4, frames held at a sweep limit (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  output enable; when low, servo=0, frame counter held at 0, position frozen.
- mode  in  2  00 hold, 01 sweep, 10 goto, 11 treated as hold.
- cmd_valid  in  1  goto target offered.
- cmd_ready  out  1  target accepted this cycle when cmd_valid && cmd_ready.
- cmd_pos  in  W  target position; clamped to [MIN_PULSE, MAX_PULSE] on acceptance.
- servo  out  1  registered PWM output.
- pos  out  W  current position register.
- dir  out  1  sweep direction: 1 = increasing, 0 = decreasing.
- frame_start  out  1  one-cycle pulse in the cycle the frame counter is 0.
- at_limit  out  1  one-cycle pulse when a sweep reaches MIN_PULSE or MAX_PULSE.
- move_done  out  1  one-cycle pulse when a goto move reaches its target.

Behaviour:
- Reset values:
  - Outputs: servo=0, pos=RESET_POS, dir=1, frame_start=0, at_limit=0, move_done=0, cmd_ready=1.
  - Internal: frame counter=0, step timer=0, active width=RESET_POS, target=RESET_POS, state=HOLD.
- Frame counter:
  - Counts 0..PERIOD_CYC-1 while en=1, then wraps to 0.
  - frame_start=en && (cnt==0).
- Active width:
  - Loaded from pos in the cycle cnt==PERIOD_CYC-1, so a new position always takes effect at a frame boundary.
  - Pulses are never truncated or stretched mid-frame.
- servo is registered: next servo = en && (cnt < active_width). This gives one cycle of latency from the counter.
- Step timer:
  - Counts 0..STEP_INTERVAL-1 while en=1 and state is SWEEP or MOVE; a tick is asserted on the wrap.
  - Cleared to 0 on every state change.
- State machine:
  - HOLD: pos frozen; cmd_ready=1. mode=01 goes to SWEEP. mode=10 stays in HOLD until a command is accepted, then goes to MOVE.
  - SWEEP: on each tick, pos moves by STEP in direction dir, saturating at the limit. When the saturated result equals a limit, dir toggles and at_limit pulses that cycle. cmd_ready=0. A mode other than 01 goes to HOLD the next cycle, keeping pos and dir.
  - MOVE: cmd_ready=0. On each tick, pos moves STEP toward the target, saturating at the target with no overshoot. When pos equals the target, move_done pulses and the state returns to HOLD. If mode != 10 mid-move, the move is aborted: go to HOLD, keep pos, no move_done.
- Command handshake:
  - Accepted only in HOLD with mode=10.
  - A target equal to pos goes to MOVE and completes on the first tick with move_done.
- Arithmetic: internal position math is done at W+1 bits to avoid overflow before the clamp.
- rst mid-operation: all state returns to reset values on the next edge; servo drops the cycle after rst is sampled.
- Simultaneous events:
  - rst has priority over everything.
  - en=0 has priority over mode and commands.
  - A mode change takes priority over a tick in the same cycle.

Optional Feature:
- Macro: SERVO_SWEEP_DWELL_EN.
- Defined: on reaching a sweep limit, SWEEP enters a DWELL sub-state.
  - Holds pos for DWELL_FRAMES frame_start pulses, then resumes stepping in the new direction.
  - at_limit pulses on arrival, not on exit.
  - The step timer is cleared on exit from DWELL.
  - A mode change during DWELL goes to HOLD.
- Undefined: no DWELL state and no dwell counter; reversal is immediate and DWELL_FRAMES is ignored.

Test Plan:
(All scenarios use PERIOD_CYC=100, MIN_PULSE=10, MAX_PULSE=30, RESET_POS=20, STEP=5, STEP_INTERVAL=4, W=8.)
- Reset, en=1, mode=00 -> servo high exactly 20 cycles of every 100; frame_start every 100 cycles; pos stays 20.
- mode=01 -> pos steps 20,25,30 on ticks every 4 cycles; at_limit pulses at 30 with dir going to 0; pos then 25,20,15,10; at_limit at 10; the measured PWM width changes only at frame boundaries.
- mode=10, cmd_pos=27 offered in HOLD -> accepted in one cycle; cmd_ready=0; pos goes 20,25,27; move_done pulses once; cmd_ready returns to 1.
- cmd_pos=200 accepted -> target clamped to 30; pos reaches 30 and move_done fires; pos never exceeds 30.
- Mid-move, switch mode to 00 -> HOLD next cycle, pos frozen, no move_done; en=0 -> servo=0 within one cycle and frame counter held at 0.
- With SERVO_SWEEP_DWELL_EN, DWELL_FRAMES=2, in sweep -> pos holds 30 for 2 frame_start pulses, then steps to 25; assert rst mid-dwell -> pos=20, dir=1, servo=0 the next cycle.

Source files
------------

// File: rtl/servo_sweep_pwm.sv
// Servo PWM generator with hold / triangular sweep / commanded-move position sequencing.
// Optional build macro SERVO_SWEEP_DWELL_EN adds a dwell of DWELL_FRAMES frames at each sweep limit.
module servo_sweep_pwm #(
    parameter int W             = 20,
    parameter int PERIOD_CYC    = 540000,
    parameter int MIN_PULSE     = 16000,
    parameter int MAX_PULSE     = 66000,
    parameter int RESET_POS     = 41000,
    parameter int STEP          = 1,
    parameter int STEP_INTERVAL = 2500,
    parameter int DWELL_FRAMES  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [1:0]   mode,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_pos,
    output logic         servo,
    output logic [W-1:0] pos,
    output logic         dir,
    output logic         frame_start,
    output logic         at_limit,
    output logic         move_done
);

    if (PERIOD_CYC >= 2**W || MIN_PULSE >= MAX_PULSE || MAX_PULSE >= PERIOD_CYC ||
        RESET_POS < MIN_PULSE || RESET_POS > MAX_PULSE || STEP < 1 ||
        STEP_INTERVAL < 1 || DWELL_FRAMES < 1) begin : g_bad_cfg
        $error("servo_sweep_pwm: illegal parameter set");
    end

    localparam logic [W-1:0]        LAST_CNT = W'(PERIOD_CYC - 1);
    localparam logic [W-1:0]        LAST_TMR = W'(STEP_INTERVAL - 1);
    localparam logic [W-1:0]        MIN_P    = W'(MIN_PULSE);
    localparam logic [W-1:0]        MAX_P    = W'(MAX_PULSE);
    localparam logic [W-1:0]        RST_P    = W'(RESET_POS);
    localparam logic signed [W:0]   STEP_S   = (W+1)'(STEP);

    localparam logic [1:0] ST_HOLD  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_MOVE  = 2'd2;
`ifdef SERVO_SWEEP_DWELL_EN
    localparam logic [1:0] ST_DWELL = 2'd3;
    localparam logic [W-1:0] LAST_DWELL = W'(DWELL_FRAMES - 1);
`endif

    logic [1:0]   state, state_nxt;
    logic [W-1:0] cnt_p0;
    logic [W-1:0] active_w;
    logic [W-1:0] tmr;
    logic [W-1:0] target, target_nxt;
    logic [W-1:0] pos_nxt;
    logic [W-1:0] step_pos;
    logic         dir_nxt;
    logic         at_limit_nxt;
    logic         move_done_nxt;
    logic         tick;

    function automatic logic [W-1:0] clamp_pos(input logic [W-1:0] v);
        if (v < MIN_P) return MIN_P;
        if (v > MAX_P) return MAX_P;
        return v;
    endfunction

    // Signed difference keeps the result between cur and tgt, so no overshoot and no wrap.
    function automatic logic [W-1:0] step_toward(input logic [W-1:0] cur, input logic [W-1:0] tgt);
        logic signed [W:0] diff;
        logic signed [W:0] nxt;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > STEP_S)
            nxt = $signed({1'b0, cur}) + STEP_S;
        else if (diff < -STEP_S)
            nxt = $signed({1'b0, cur}) - STEP_S;
        else
            nxt = $signed({1'b0, tgt});
        return W'(nxt);
    endfunction

    assign cmd_ready   = (state == ST_HOLD);
    assign frame_start = !rst && en && (cnt_p0 == '0);
    assign tick        = en && (state == ST_SWEEP || state == ST_MOVE) && (tmr == LAST_TMR);

`ifdef SERVO_SWEEP_DWELL_EN
    logic [W-1:0] dwell_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != ST_DWELL)
            dwell_cnt <= '0;
        else if (frame_start)
            dwell_cnt <= dwell_cnt + 1'b1;
    end
`endif

    always_comb begin
        state_nxt     = state;
        pos_nxt       = pos;
        dir_nxt       = dir;
        target_nxt    = target;
        at_limit_nxt  = 1'b0;
        move_done_nxt = 1'b0;
        step_pos      = pos;
        if (en) begin
            case (state)
                ST_HOLD: begin
                    if (mode == 2'b01) begin
                        state_nxt = ST_SWEEP;
                    end else if (mode == 2'b10 && cmd_valid) begin
                        target_nxt = clamp_pos(cmd_pos);
                        state_nxt  = ST_MOVE;
                    end
                end
                ST_SWEEP: begin
                    if (mode != 2'b01) begin
                        state_nxt = ST_HOLD;
                    end else if (tick) begin
                        step_pos = step_toward(pos, dir ? MAX_P : MIN_P);
                        pos_nxt  = step_pos;
                        if ((dir && step_pos == MAX_P) || (!dir && step_pos == MIN_P)) begin
                            dir_nxt      = !dir;
                            at_limit_nxt = 1'b1;
`ifdef SERVO_SWEEP_DWELL_EN
                            state_nxt    = ST_DWELL;
`endif
                        end
                    end
                end
                ST_MOVE: begin
                    if (mode != 2'b10) begin
                        state_nxt = ST_HOLD;
                    end else if (tick) begin
                        step_pos = step_toward(pos, target);
                        pos_nxt  = step_pos;
                        if (step_pos == target) begin
                            move_done_nxt = 1'b1;
                            state_nxt     = ST_HOLD;
                        end
                    end
                end
`ifdef SERVO_SWEEP_DWELL_EN
                ST_DWELL: begin
                    if (mode != 2'b01)
                        state_nxt = ST_HOLD;
                    else if (frame_start && dwell_cnt == LAST_DWELL)
                        state_nxt = ST_SWEEP;
                end
`endif
                default: state_nxt = ST_HOLD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_HOLD;
            pos       <= RST_P;
            dir       <= 1'b1;
            target    <= RST_P;
            at_limit  <= 1'b0;
            move_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            pos       <= pos_nxt;
            dir       <= dir_nxt;
            target    <= target_nxt;
            at_limit  <= at_limit_nxt;
            move_done <= move_done_nxt;
        end
    end

    // Step timer restarts whenever the state changes so every phase begins with a full interval.
    always_ff @(posedge clk) begin
        if (rst || state_nxt != state)
            tmr <= '0;
        else if (en && (state == ST_SWEEP || state == ST_MOVE))
            tmr <= (tmr == LAST_TMR) ? '0 : tmr + 1'b1;
    end

    // Stage p0: frame counter; the width latches only at the frame boundary.
    always_ff @(posedge clk) begin
        if (rst || !en)
            cnt_p0 <= '0;
        else
            cnt_p0 <= (cnt_p0 == LAST_CNT) ? '0 : cnt_p0 + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            active_w <= RST_P;
        else if (en && cnt_p0 == LAST_CNT)
            active_w <= pos;
    end

    // Stage p1: registered PWM compare.
    always_ff @(posedge clk) begin
        if (rst)
            servo <= 1'b0;
        else
            servo <= en && (cnt_p0 < active_w);
    end

endmodule

// File: tb/tb_servo_sweep_pwm.sv
// Directed bench for servo_sweep_pwm with small parameters (100-cycle frame, limits 10..30, step 5 every 4 cycles).
module tb_servo_sweep_pwm;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_pos;
    logic         servo;
    logic [W-1:0] pos;
    logic         dir;
    logic         frame_start;
    logic         at_limit;
    logic         move_done;

    int n_chk  = 0;
    int n_pass = 0;
    int acc    = 0;
    int last_w = -1;
    int md_cnt = 0;

    always #5 clk = ~clk;

    servo_sweep_pwm #(
        .W(W), .PERIOD_CYC(100), .MIN_PULSE(10), .MAX_PULSE(30), .RESET_POS(20),
        .STEP(5), .STEP_INTERVAL(4), .DWELL_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pos(cmd_pos),
        .servo(servo), .pos(pos), .dir(dir), .frame_start(frame_start),
        .at_limit(at_limit), .move_done(move_done)
    );

    // Per-frame high-time measurement and move_done pulse counter.
    always @(negedge clk) begin
        if (move_done === 1'b1) md_cnt++;
        if (frame_start === 1'b1) begin
            last_w = acc;
            acc    = (servo === 1'b1) ? 1 : 0;
        end else if (servo === 1'b1) begin
            acc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_fs(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (frame_start === 1'b1) break;
            step(1);
        end
        check(tag, frame_start, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, fs, md0;
        rst = 1'b1; en = 1'b0; mode = 2'b00; cmd_valid = 1'b0; cmd_pos = '0;
        step(3);
        check("rst_servo", servo, 0);
        check("rst_pos", pos, 20);
        check("rst_dir", dir, 1);
        check("rst_fs", frame_start, 0);
        check("rst_atl", at_limit, 0);
        check("rst_md", move_done, 0);
        check("rst_rdy", cmd_ready, 1);

        rst = 1'b0; en = 1'b1; #1;
        check("fs_first", frame_start, 1);
        hi = 0; fs = 0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            hi += int'(servo);
            fs += int'(frame_start);
        end
        check("hold_hi", hi, 40);
        check("hold_fs", fs, 2);
        check("hold_pos", pos, 20);

`ifdef SERVO_SWEEP_DWELL_EN
        mode = 2'b01;
        step(9);
        check("dw_p30", pos, 30);
        check("dw_atl", at_limit, 1);
        check("dw_dir", dir, 0);
        step(2);
        check("dw_hold", pos, 30);
        rst = 1'b1;
        step(1);
        check("dw_rst_pos", pos, 20);
        check("dw_rst_dir", dir, 1);
        check("dw_rst_servo", servo, 0);
        rst = 1'b0;
        step(9);
        check("dw2_p30", pos, 30);
        wait_fs("dw_fs1");
        step(1);
        wait_fs("dw_fs2");
        check("dw_still30", pos, 30);
        step(4);
        check("dw_wait30", pos, 30);
        step(1);
        check("dw_resume25", pos, 25);
`else
        mode = 2'b01;
        step(1);
        check("sw_rdy", cmd_ready, 0);
        check("sw_pos0", pos, 20);
        step(4);
        check("sw_p25", pos, 25);
        check("sw_dir_up", dir, 1);
        step(4);
        check("sw_p30", pos, 30);
        check("sw_atl_hi", at_limit, 1);
        check("sw_dir_dn", dir, 0);
        step(1);
        check("sw_atl_lo", at_limit, 0);
        step(3);
        check("sw_p25b", pos, 25);
        step(4);
        check("sw_p20", pos, 20);
        step(4);
        check("sw_p15", pos, 15);
        step(4);
        check("sw_p10", pos, 10);
        check("sw_atl_min", at_limit, 1);
        check("sw_dir_up2", dir, 1);

        mode = 2'b00;
        step(1);
        check("sw_rdy_back", cmd_ready, 1);
        step(75);
        check("frame_w_sweep", last_w, 20);
        step(100);
        check("frame_w_new", last_w, 10);
        check("hold_pos10", pos, 10);

        check("pre_rst_servo", servo, 1);
        rst = 1'b1;
        step(1);
        check("mid_rst_servo", servo, 0);
        check("mid_rst_pos", pos, 20);
        check("mid_rst_rdy", cmd_ready, 1);
        rst = 1'b0;

        mode = 2'b10; cmd_valid = 1'b1; cmd_pos = 8'd27;
        check("gt_rdy_pre", cmd_ready, 1);
        md0 = md_cnt;
        step(1);
        cmd_valid = 1'b0;
        check("gt_rdy_busy", cmd_ready, 0);
        check("gt_pos0", pos, 20);
        step(4);
        check("gt_p25", pos, 25);
        check("gt_md0", move_done, 0);
        step(4);
        check("gt_p27", pos, 27);
        check("gt_done", move_done, 1);
        check("gt_rdy_back", cmd_ready, 1);
        step(1);
        check("gt_done_lo", move_done, 0);
        check("gt_done_once", md_cnt - md0, 1);

        cmd_valid = 1'b1; cmd_pos = 8'd200;
        step(1);
        cmd_valid = 1'b0;
        check("cl_rdy", cmd_ready, 0);
        step(4);
        check("cl_p30", pos, 30);
        check("cl_done", move_done, 1);
        step(4);
        check("cl_hold", pos, 30);

        cmd_valid = 1'b1; cmd_pos = 8'd12;
        step(1);
        cmd_valid = 1'b0;
        md0 = md_cnt;
        step(4);
        check("ab_p25", pos, 25);
        step(3);
        mode = 2'b00;
        step(1);
        check("ab_rdy", cmd_ready, 1);
        check("ab_pos", pos, 25);
        step(8);
        check("ab_frozen", pos, 25);
        check("ab_no_done", md_cnt - md0, 0);

        wait_fs("en_fs_wait");
        step(2);
        check("en_servo_pre", servo, 1);
        en = 1'b0;
        step(1);
        check("en_servo_off", servo, 0);
        check("en_fs_off", frame_start, 0);
        step(5);
        check("en_servo_still", servo, 0);
        en = 1'b1; #1;
        check("en_fs_resume", frame_start, 1);
        step(1);
        check("en_servo_on", servo, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
